// File: rtl/mips_pkg.sv
// Shared MIPS32 decode constants: opcodes, instruction field positions and
// small decode helpers used by the ID stage.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  // Logical immediates and LUI take a zero-extended immediate; everything else sign-extends.
  function automatic logic [31:0] extend_imm(input logic [5:0] opcode, input logic [15:0] imm);
    logic [31:0] ext;
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: ext = {16'h0000, imm};
      default:                          ext = {{16{imm[15]}}, imm};
    endcase
    return ext;
  endfunction

  function automatic logic is_load(input logic [5:0] opcode);
    logic ld;
    case (opcode)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: ld = 1'b1;
      default:                             ld = 1'b0;
    endcase
    return ld;
  endfunction

endpackage

// File: rtl/decode_operand_stage_if.sv
// Fetch-to-decode handshake bundle: instruction, PC+4, flush and valid/ready.
interface decode_operand_stage_if;

  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_instr;
  logic [31:0] i_pc_plus4;
  logic        i_flush;

  modport master (
    output i_valid,
    output i_instr,
    output i_pc_plus4,
    output i_flush,
    input  o_ready
  );

  modport slave (
    input  i_valid,
    input  i_instr,
    input  i_pc_plus4,
    input  i_flush,
    output o_ready
  );

endinterface

// File: rtl/decode_operand_stage_operand_bypass.sv
// operand_bypass: priority forwarding mux for one source operand
// (EX > MEM > WB > register file, register $0 always reads as zero).
module operand_bypass #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  input  logic          ex_we,
  input  logic [AW-1:0] ex_waddr,
  input  logic [DW-1:0] ex_wdata,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_wdata,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_waddr,
  input  logic [DW-1:0] wb_wdata,
  output logic [DW-1:0] operand
);

  // WB must be forwarded too: the register file only commits it on the coming edge.
  always_comb begin
    operand = rdata;
    if (raddr == '0) begin
      operand = '0;
    end else if (ex_we && (ex_waddr == raddr)) begin
      operand = ex_wdata;
    end else if (mem_we && (mem_waddr == raddr)) begin
      operand = mem_wdata;
    end else if (wb_we && (wb_waddr == raddr)) begin
      operand = wb_wdata;
    end else begin
      operand = rdata;
    end
  end

endmodule

// File: rtl/decode_operand_stage.sv
// MIPS32 ID stage: register-file addressing, operand bypass, immediate
// extension and the ID/EX pipeline register. LOAD_USE_STALL_EN enables the load-use bubble.
module decode_operand_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  decode_operand_stage_if.slave         fif,
  output logic [AW-1:0]                 o_raddr1,
  output logic [AW-1:0]                 o_raddr2,
  input  logic [DW-1:0]                 i_rdata1,
  input  logic [DW-1:0]                 i_rdata2,
  input  logic                          i_ex_we,
  input  logic [AW-1:0]                 i_ex_waddr,
  input  logic [DW-1:0]                 i_ex_wdata,
  input  logic                          i_mem_we,
  input  logic [AW-1:0]                 i_mem_waddr,
  input  logic [DW-1:0]                 i_mem_wdata,
  input  logic                          i_wb_we,
  input  logic [AW-1:0]                 i_wb_waddr,
  input  logic [DW-1:0]                 i_wb_wdata,
  input  logic                          i_ex_ready,
  output logic                          o_valid,
  output logic [DW-1:0]                 o_op1,
  output logic [DW-1:0]                 o_op2,
  output logic [DW-1:0]                 o_imm,
  output logic [5:0]                    o_opcode,
  output logic [5:0]                    o_funct,
  output logic [4:0]                    o_shamt,
  output logic [AW-1:0]                 o_rt,
  output logic [AW-1:0]                 o_rd,
  output logic [DW-1:0]                 o_pc_plus4
);

  logic [5:0]    opcode_s;
  logic [AW-1:0] rs_s;
  logic [AW-1:0] rt_s;
  logic [AW-1:0] rd_s;
  logic [4:0]    shamt_s;
  logic [5:0]    funct_s;
  logic [DW-1:0] imm_s;
  logic [DW-1:0] op1_s;
  logic [DW-1:0] op2_s;
  logic          adv_s;
  logic          hazard_s;
  logic          ready_s;

  assign opcode_s = fif.i_instr[OPCODE_MSB:OPCODE_LSB];
  assign rs_s     = fif.i_instr[RS_MSB:RS_LSB];
  assign rt_s     = fif.i_instr[RT_MSB:RT_LSB];
  assign rd_s     = fif.i_instr[RD_MSB:RD_LSB];
  assign shamt_s  = fif.i_instr[SHAMT_MSB:SHAMT_LSB];
  assign funct_s  = fif.i_instr[FUNCT_MSB:FUNCT_LSB];
  assign imm_s    = extend_imm(opcode_s, fif.i_instr[IMM_MSB:IMM_LSB]);

  assign o_raddr1 = rs_s;
  assign o_raddr2 = rt_s;

  operand_bypass #(.DW(DW), .AW(AW)) u_bypass_rs (
    .raddr     (rs_s),
    .rdata     (i_rdata1),
    .ex_we     (i_ex_we),
    .ex_waddr  (i_ex_waddr),
    .ex_wdata  (i_ex_wdata),
    .mem_we    (i_mem_we),
    .mem_waddr (i_mem_waddr),
    .mem_wdata (i_mem_wdata),
    .wb_we     (i_wb_we),
    .wb_waddr  (i_wb_waddr),
    .wb_wdata  (i_wb_wdata),
    .operand   (op1_s)
  );

  operand_bypass #(.DW(DW), .AW(AW)) u_bypass_rt (
    .raddr     (rt_s),
    .rdata     (i_rdata2),
    .ex_we     (i_ex_we),
    .ex_waddr  (i_ex_waddr),
    .ex_wdata  (i_ex_wdata),
    .mem_we    (i_mem_we),
    .mem_waddr (i_mem_waddr),
    .mem_wdata (i_mem_wdata),
    .wb_we     (i_wb_we),
    .wb_waddr  (i_wb_waddr),
    .wb_wdata  (i_wb_wdata),
    .operand   (op2_s)
  );

`ifdef LOAD_USE_STALL_EN
  // A load sitting in ID/EX has no EX-stage result yet; hold the consumer one cycle.
  always_comb begin
    hazard_s = o_valid & is_load(o_opcode) & (o_rt != '0) &
               ((o_rt == rs_s) | (o_rt == rt_s));
  end
`else
  assign hazard_s = 1'b0;
`endif

  always_comb begin
    adv_s   = ~o_valid | i_ex_ready;
    ready_s = adv_s & ~hazard_s;
  end

  assign fif.o_ready = ready_s;

  // ID/EX register: bubble on hazard, flush clears valid but payload still loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid    <= 1'b0;
      o_op1      <= '0;
      o_op2      <= '0;
      o_imm      <= '0;
      o_opcode   <= 6'h00;
      o_funct    <= 6'h00;
      o_shamt    <= 5'h00;
      o_rt       <= '0;
      o_rd       <= '0;
      o_pc_plus4 <= '0;
    end else if (adv_s) begin
      if (!hazard_s) begin
        o_valid    <= fif.i_valid & ~fif.i_flush;
        o_op1      <= op1_s;
        o_op2      <= op2_s;
        o_imm      <= imm_s;
        o_opcode   <= opcode_s;
        o_funct    <= funct_s;
        o_shamt    <= shamt_s;
        o_rt       <= rt_s;
        o_rd       <= rd_s;
        o_pc_plus4 <= fif.i_pc_plus4;
      end else begin
        o_valid    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_operand_stage.sv
// Self-checking bench for decode_operand_stage; expected ID/EX contents go through a scoreboard queue.
module tb_decode_operand_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc;
  } obs_t;

  typedef struct {
    logic [31:0] instr;
    logic        exw;  logic [4:0] exa;  logic [31:0] exd;
    logic        memw; logic [4:0] mema; logic [31:0] memd;
    logic        wbw;  logic [4:0] wba;  logic [31:0] wbd;
    logic [31:0] r1;   logic [31:0] r2;
    logic [31:0] op1;  logic [31:0] op2;
  } byp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  o_raddr1, o_raddr2;
  logic [31:0] i_rdata1, i_rdata2;
  logic        i_ex_we, i_mem_we, i_wb_we;
  logic [4:0]  i_ex_waddr, i_mem_waddr, i_wb_waddr;
  logic [31:0] i_ex_wdata, i_mem_wdata, i_wb_wdata;
  logic        i_ex_ready;
  logic        o_valid;
  logic [31:0] o_op1, o_op2, o_imm, o_pc_plus4;
  logic [5:0]  o_opcode, o_funct;
  logic [4:0]  o_shamt, o_rt, o_rd;

  obs_t sb_q[$];
  obs_t exp_v;
  obs_t held_v;
  int   n_cmp = 0;
  int   n_err = 0;

  decode_operand_stage_if fif();

  always #5 clk = ~clk;

  decode_operand_stage dut (
    .clk         (clk),
    .reset       (reset),
    .fif         (fif),
    .o_raddr1    (o_raddr1),
    .o_raddr2    (o_raddr2),
    .i_rdata1    (i_rdata1),
    .i_rdata2    (i_rdata2),
    .i_ex_we     (i_ex_we),
    .i_ex_waddr  (i_ex_waddr),
    .i_ex_wdata  (i_ex_wdata),
    .i_mem_we    (i_mem_we),
    .i_mem_waddr (i_mem_waddr),
    .i_mem_wdata (i_mem_wdata),
    .i_wb_we     (i_wb_we),
    .i_wb_waddr  (i_wb_waddr),
    .i_wb_wdata  (i_wb_wdata),
    .i_ex_ready  (i_ex_ready),
    .o_valid     (o_valid),
    .o_op1       (o_op1),
    .o_op2       (o_op2),
    .o_imm       (o_imm),
    .o_opcode    (o_opcode),
    .o_funct     (o_funct),
    .o_shamt     (o_shamt),
    .o_rt        (o_rt),
    .o_rd        (o_rd),
    .o_pc_plus4  (o_pc_plus4)
  );

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'h00, 6'h21};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] instr);
    logic [5:0] op;
    op = instr[31:26];
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E || op == 6'h0F)
      return {16'h0000, instr[15:0]};
    else
      return {{16{instr[15]}}, instr[15:0]};
  endfunction

  function automatic obs_t expect_of(input logic [31:0] instr, input logic [31:0] pc,
                                     input logic [31:0] op1, input logic [31:0] op2);
    obs_t e;
    e.valid  = 1'b1;
    e.op1    = op1;
    e.op2    = op2;
    e.imm    = ref_imm(instr);
    e.opcode = instr[31:26];
    e.funct  = instr[5:0];
    e.shamt  = instr[10:6];
    e.rt     = instr[20:16];
    e.rd     = instr[15:11];
    e.pc     = pc;
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.valid  = o_valid;
    o.op1    = o_op1;
    o.op2    = o_op2;
    o.imm    = o_imm;
    o.opcode = o_opcode;
    o.funct  = o_funct;
    o.shamt  = o_shamt;
    o.rt     = o_rt;
    o.rd     = o_rd;
    o.pc     = o_pc_plus4;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp();
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
    fif.i_valid    = 1'b1;
    fif.i_instr    = instr;
    fif.i_pc_plus4 = pc;
    i_rdata1       = r1;
    i_rdata2       = r2;
  endtask

  task automatic clear_bypass();
    i_ex_we  = 1'b0; i_ex_waddr  = 5'd0; i_ex_wdata  = 32'h0;
    i_mem_we = 1'b0; i_mem_waddr = 5'd0; i_mem_wdata = 32'h0;
    i_wb_we  = 1'b0; i_wb_waddr  = 5'd0; i_wb_wdata  = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] instr;
    instr = r_type(5'd1, 5'd2, 5'd3);
    reset = 1'b1;
    fif.i_flush = 1'b0;
    i_ex_ready  = 1'b1;
    clear_bypass();
    present(instr, 32'h0000_0100, 32'h11, 32'h22);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (observe() !== obs_t'('0)) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got %h want 0", i, observe());
      end
    end
    reset = 1'b0;
    sb_q.push_back(expect_of(instr, 32'h0000_0100, 32'h11, 32'h22));
    tick();
    pop_exp();
    n_cmp++;
    if (observe() !== exp_v) begin
      n_err++;
      $display("FAIL first_capture: got %h want %h", observe(), exp_v);
    end
  endtask

  task automatic test_addu();
    logic [31:0] instr;
    instr = r_type(5'd1, 5'd2, 5'd3);
    present(instr, 32'h0000_0104, 32'd5, 32'd7);
    @(negedge clk);
    n_cmp++;
    if ({fif.o_ready, o_raddr1, o_raddr2} !== {1'b1, 5'd1, 5'd2}) begin
      n_err++;
      $display("FAIL addu_addr: got ready=%b ra1=%0d ra2=%0d want 1/1/2", fif.o_ready, o_raddr1, o_raddr2);
    end
    sb_q.push_back(expect_of(instr, 32'h0000_0104, 32'd5, 32'd7));
    tick();
    pop_exp();
    n_cmp++;
    if (observe() !== exp_v || o_rd !== 5'd3) begin
      n_err++;
      $display("FAIL addu: got %h want %h", observe(), exp_v);
    end
  endtask

  task automatic test_bypass();
    byp_t tbl[6];
    tbl[0] = '{r_type(5'd4, 5'd0, 5'd6), 1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB, 1'b1, 5'd4, 32'hCC, 32'hDD, 32'h33, 32'hAA, 32'h0};
    tbl[1] = '{r_type(5'd4, 5'd0, 5'd6), 1'b0, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB, 1'b1, 5'd4, 32'hCC, 32'hDD, 32'h33, 32'hBB, 32'h0};
    tbl[2] = '{r_type(5'd4, 5'd0, 5'd6), 1'b0, 5'd4, 32'hAA, 1'b0, 5'd4, 32'hBB, 1'b1, 5'd4, 32'hCC, 32'hDD, 32'h33, 32'hCC, 32'h0};
    tbl[3] = '{r_type(5'd4, 5'd0, 5'd6), 1'b0, 5'd4, 32'hAA, 1'b0, 5'd4, 32'hBB, 1'b0, 5'd4, 32'hCC, 32'hDD, 32'h33, 32'hDD, 32'h0};
    tbl[4] = '{r_type(5'd0, 5'd0, 5'd6), 1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB, 1'b1, 5'd0, 32'hFF, 32'h55, 32'h66, 32'h0,  32'h0};
    tbl[5] = '{r_type(5'd1, 5'd9, 5'd6), 1'b1, 5'd8, 32'hEE, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h77, 32'h11, 32'h22, 32'h11, 32'h99};
    for (int i = 0; i < 6; i++) begin
      i_ex_we  = tbl[i].exw;  i_ex_waddr  = tbl[i].exa;  i_ex_wdata  = tbl[i].exd;
      i_mem_we = tbl[i].memw; i_mem_waddr = tbl[i].mema; i_mem_wdata = tbl[i].memd;
      i_wb_we  = tbl[i].wbw;  i_wb_waddr  = tbl[i].wba;  i_wb_wdata  = tbl[i].wbd;
      present(tbl[i].instr, 32'h0000_0200 + 32'(i * 4), tbl[i].r1, tbl[i].r2);
      sb_q.push_back(expect_of(tbl[i].instr, 32'h0000_0200 + 32'(i * 4), tbl[i].op1, tbl[i].op2));
      tick();
      pop_exp();
      n_cmp++;
      if (observe() !== exp_v) begin
        n_err++;
        $display("FAIL bypass[%0d]: got op1=%h op2=%h want op1=%h op2=%h", i, o_op1, o_op2, exp_v.op1, exp_v.op2);
      end
    end
    clear_bypass();
  endtask

  task automatic test_imm();
    logic [31:0] instr;
    instr = i_type(6'h0C, 5'd1, 5'd2, 16'h8001);
    present(instr, 32'h0000_0300, 32'h1, 32'h2);
    sb_q.push_back(expect_of(instr, 32'h0000_0300, 32'h1, 32'h2));
    tick();
    pop_exp();
    n_cmp++;
    if (observe() !== exp_v || o_imm !== 32'h0000_8001) begin
      n_err++;
      $display("FAIL andi_imm: got %h want %h", o_imm, 32'h0000_8001);
    end
    instr = i_type(6'h08, 5'd1, 5'd2, 16'h8001);
    present(instr, 32'h0000_0304, 32'h1, 32'h2);
    sb_q.push_back(expect_of(instr, 32'h0000_0304, 32'h1, 32'h2));
    tick();
    pop_exp();
    n_cmp++;
    if (observe() !== exp_v || o_imm !== 32'hFFFF_8001) begin
      n_err++;
      $display("FAIL addi_imm: got %h want %h", o_imm, 32'hFFFF_8001);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] lw, addu;
    lw   = i_type(6'h23, 5'd1, 5'd5, 16'h0004);
    addu = r_type(5'd5, 5'd2, 5'd6);
    present(lw, 32'h0000_0400, 32'h1000, 32'h50);
    sb_q.push_back(expect_of(lw, 32'h0000_0400, 32'h1000, 32'h50));
    tick();
    pop_exp();
    n_cmp++;
    if (observe() !== exp_v) begin
      n_err++;
      $display("FAIL lw_capture: got %h want %h", observe(), exp_v);
    end
    present(addu, 32'h0000_0404, 32'h500, 32'h7);
`ifdef LOAD_USE_STALL_EN
    @(negedge clk);
    n_cmp++;
    if (fif.o_ready !== 1'b0) begin
      n_err++;
      $display("FAIL lu_stall_ready: got %b want 0", fif.o_ready);
    end
    tick();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL lu_bubble: got %b want 0", o_valid);
    end
    i_mem_we = 1'b1; i_mem_waddr = 5'd5; i_mem_wdata = 32'h1234;
    @(negedge clk);
    n_cmp++;
    if (fif.o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL lu_release_ready: got %b want 1", fif.o_ready);
    end
    sb_q.push_back(expect_of(addu, 32'h0000_0404, 32'h1234, 32'h7));
`else
    @(negedge clk);
    n_cmp++;
    if (fif.o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL lu_no_stall: got %b want 1", fif.o_ready);
    end
    sb_q.push_back(expect_of(addu, 32'h0000_0404, 32'h500, 32'h7));
`endif
    tick();
    pop_exp();
    n_cmp++;
    if (observe() !== exp_v) begin
      n_err++;
      $display("FAIL lu_consumer: got op1=%h valid=%b want op1=%h valid=1", o_op1, o_valid, exp_v.op1);
    end
    clear_bypass();
  endtask

  task automatic test_stall_flush();
    logic [31:0] instr;
    instr = r_type(5'd1, 5'd2, 5'd3);
    present(instr, 32'h0000_0500, 32'hA, 32'hB);
    sb_q.push_back(expect_of(instr, 32'h0000_0500, 32'hA, 32'hB));
    tick();
    pop_exp();
    held_v = exp_v;
    n_cmp++;
    if (observe() !== held_v) begin
      n_err++;
      $display("FAIL stall_capture: got %h want %h", observe(), held_v);
    end
    i_ex_ready = 1'b0;
    present(r_type(5'd7, 5'd8, 5'd9), 32'h0000_0504, 32'hE, 32'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (fif.o_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_ready[%0d]: got %b want 0", i, fif.o_ready);
      end
      tick();
      n_cmp++;
      if (observe() !== held_v) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got %h want %h", i, observe(), held_v);
      end
    end
    i_ex_ready  = 1'b1;
    fif.i_flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (fif.o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL release_ready: got %b want 1", fif.o_ready);
    end
    tick();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush: got %b want 0", o_valid);
    end
    fif.i_flush = 1'b0;
    fif.i_valid = 1'b0;
    tick();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle: got %b want 0", o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_bypass();
    test_imm();
    test_load_use();
    test_stall_flush();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
